// File: rtl/hazard_scoreboard.sv
// Hazard unit beside ID: N-stage forward select, long-op register scoreboard and deferred redirect flush.
// Optional HAZARD_PERF_CNT_EN adds saturating stall-cycle and redirect-flush counters.
module hazard_scoreboard #(
    parameter int unsigned NUM_FWD_STAGES  = 3,
    parameter int unsigned REG_IDX_W       = 5,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned FSEL_W         = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_id_valid,
    input  logic [REG_IDX_W-1:0]                i_id_rs1,
    input  logic [REG_IDX_W-1:0]                i_id_rs2,
    input  logic                                i_id_uses_rs1,
    input  logic                                i_id_uses_rs2,
    input  logic [REG_IDX_W-1:0]                i_id_rd,
    input  logic                                i_id_writes_rd,
    input  logic                                i_id_is_long,
    input  logic [NUM_FWD_STAGES*REG_IDX_W-1:0] i_stg_rd,
    input  logic [NUM_FWD_STAGES-1:0]           i_stg_wr,
    input  logic [NUM_FWD_STAGES-1:0]           i_stg_rdy,
    input  logic                                i_lu_done,
    input  logic [REG_IDX_W-1:0]                i_lu_rd,
    input  logic                                i_all_ready,
    input  logic                                i_redirect,
    output logic [FSEL_W-1:0]                   o_fwd1_sel,
    output logic [FSEL_W-1:0]                   o_fwd2_sel,
    output logic                                o_ifid_stall,
    output logic [3:0]                          o_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]                         o_perf_stall_cycles,
    output logic [31:0]                         o_perf_flush_events,
`endif
    output logic [2**REG_IDX_W-1:0]             o_lu_busy_vec
);

    localparam int unsigned NUM_REGS = 2**REG_IDX_W;
    localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);

    logic [NUM_REGS-1:0]           r_busy;
    logic [CNT_W-1:0]              r_cnt;
    logic                          r_redirect_pending;

    logic [1:0][REG_IDX_W-1:0]     w_rs;
    logic [1:0]                    w_uses;
    logic [1:0][FSEL_W-1:0]        w_sel;
    logic [1:0]                    w_hit;
    logic [1:0]                    w_hit_rdy;
    logic [1:0]                    w_src_stall;
    logic                          w_waw_stall;
    logic                          w_struct_stall;
    logic                          w_hazard_stall;
    logic                          w_redirect_flush;
    logic                          w_stall_out;
    logic                          w_fire_long;
    logic [NUM_REGS-1:0]           w_busy_nxt;

    assign w_rs   = {i_id_rs2, i_id_rs1};
    assign w_uses = {i_id_uses_rs2, i_id_uses_rs1};

    // Scan oldest to youngest so the youngest matching stage is the last one written.
    always_comb begin
        w_sel       = '0;
        w_hit       = '0;
        w_hit_rdy   = '0;
        w_src_stall = '0;
        for (int s = 0; s < 2; s++) begin
            for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
                if (w_uses[s] && (w_rs[s] != '0) && i_stg_wr[k-1] &&
                    (i_stg_rd[k*REG_IDX_W-1 -: REG_IDX_W] == w_rs[s])) begin
                    w_sel[s]     = FSEL_W'(k);
                    w_hit[s]     = 1'b1;
                    w_hit_rdy[s] = i_stg_rdy[k-1];
                end
            end
            if (w_uses[s] && (w_rs[s] != '0)) begin
                w_src_stall[s] = w_hit[s] ? ~w_hit_rdy[s] : r_busy[w_rs[s]];
            end
        end
    end

    assign w_waw_stall      = i_id_writes_rd && (i_id_rd != '0) && r_busy[i_id_rd];
    assign w_struct_stall   = i_id_is_long && (r_cnt == CNT_W'(MAX_OUTSTANDING));
    assign w_hazard_stall   = (|w_src_stall) || w_waw_stall || w_struct_stall;

    // Redirect flush wins over a hazard bubble in the same cycle.
    assign w_redirect_flush = i_all_ready && (i_redirect || r_redirect_pending);
    assign w_stall_out      = i_id_valid && i_all_ready && w_hazard_stall && !w_redirect_flush;
    assign w_fire_long      = i_id_valid && i_all_ready && !w_hazard_stall &&
                              !w_redirect_flush && i_id_is_long;

    assign o_fwd1_sel    = w_sel[0];
    assign o_fwd2_sel    = w_sel[1];
    assign o_ifid_stall  = w_stall_out;
    assign o_flush       = {1'b0, w_redirect_flush, w_redirect_flush | w_stall_out, w_redirect_flush};
    assign o_lu_busy_vec = r_busy;

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_fire_long && (i_id_rd != '0)) begin
            w_busy_nxt[i_id_rd] = 1'b1;
        end
        if (i_lu_done) begin
            w_busy_nxt[i_lu_rd] = 1'b0;
        end
    end

    // Scoreboard bits and in-flight long-op count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            case ({w_fire_long, i_lu_done})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Holds a redirect seen during a memory stall until the pipeline can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_pending <= 1'b0;
        end else if (i_all_ready) begin
            r_redirect_pending <= 1'b0;
        end else if (i_redirect) begin
            r_redirect_pending <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_stall_out && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_redirect_flush && (r_perf_flush != 32'hFFFF_FFFF)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign o_perf_stall_cycles = r_perf_stall;
    assign o_perf_flush_events = r_perf_flush;
`endif

    a_done_busy: assert property (@(posedge clk) disable iff (!rst_n)
        i_lu_done |-> r_busy[i_lu_rd]);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        (i_lu_done && !w_fire_long) |-> (r_cnt != '0));
    a_no_set_clear: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_fire_long && i_lu_done && (i_id_rd != '0) && (i_id_rd == i_lu_rd)));

endmodule
